// File: rtl/rv32i_pkg.sv
// Shared types for the RV32I core pipeline.
// Holds datapath widths, forwarding select and hazard FSM state encodings.
package rv32i_pkg;

  localparam int DPW = 32;
  localparam int ADW = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } hz_state_t;

endpackage

// File: rtl/fwd_unit.sv
// E-stage operand forwarding select for one source register.
// Ports: rs (E source), rdM/rdW + regwriteM/W (producers), sel (fwd_sel_t).
import rv32i_pkg::*;

module fwd_unit #(
  parameter int AW = ADW
) (
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rdM,
  input  logic [AW-1:0] rdW,
  input  logic          regwriteM,
  input  logic          regwriteW,
  output fwd_sel_t      sel
);

  // M is younger than W, so it wins; x0 is never forwarded.
  always_comb begin
    sel = FWD_RF;
    if (regwriteM && rdM != '0 && rdM == rs)
      sel = FWD_M;
    else if (regwriteW && rdW != '0 && rdW == rs)
      sel = FWD_W;
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: forwarding, load-use stall, redirect flush,
// memory-wait freeze with timeout error, saturating stall/flush counters.
import rv32i_pkg::*;

module hazard_ctrl_unit #(
  parameter int TMO_CYC = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [ADW-1:0]   rs1D,
  input  logic [ADW-1:0]   rs2D,
  input  logic [ADW-1:0]   rs1E,
  input  logic [ADW-1:0]   rs2E,
  input  logic [ADW-1:0]   rdE,
  input  logic             regwriteE,
  input  logic             resultsrcE,
  input  logic [ADW-1:0]   rdM,
  input  logic [ADW-1:0]   rdW,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             pcsrcE,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             err_clr,
  input  logic             cnt_clr,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             stallW,
  output logic             flushD,
  output logic             flushE,
  output logic             err_tmo,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int TW = $clog2(TMO_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  hz_state_t      state;
  logic [TW-1:0]  tmo_cnt;
  fwd_sel_t       fwd_a;
  fwd_sel_t       fwd_b;
  logic           lduse;
  logic           freeze;
  logic           redir;
  logic           ldstall;

  fwd_unit u_fwd_a (
    .rs        (rs1E),
    .rdM       (rdM),
    .rdW       (rdW),
    .regwriteM (regwriteM),
    .regwriteW (regwriteW),
    .sel       (fwd_a)
  );

  fwd_unit u_fwd_b (
    .rs        (rs2E),
    .rdM       (rdM),
    .rdW       (rdW),
    .regwriteM (regwriteM),
    .regwriteW (regwriteW),
    .sel       (fwd_b)
  );

  assign forwardAE = arst ? FWD_RF : fwd_a;
  assign forwardBE = arst ? FWD_RF : fwd_b;

  assign lduse = resultsrcE && regwriteE && rdE != '0 &&
                 (rdE == rs1D || rdE == rs2D);

  // A zero-wait access (ready in the request cycle) never freezes.
  assign freeze = (state == MEM_WAIT && !dmem_ready) ||
                  (state == ERROR) ||
                  (state == RUN && dmem_req && !dmem_ready);

  // Mutually exclusive priority terms: freeze > redirect > load-use.
  assign redir   = !freeze && pcsrcE;
  assign ldstall = !freeze && !pcsrcE && lduse;

  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    stallW = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    if (arst) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else begin
      unique case (1'b1)
        freeze: begin
          stallF = 1'b1;
          stallD = 1'b1;
          stallE = 1'b1;
          stallM = 1'b1;
          stallW = 1'b1;
        end
        redir: begin
          flushD = 1'b1;
          flushE = 1'b1;
        end
        ldstall: begin
          stallF = 1'b1;
          stallD = 1'b1;
          flushE = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state   <= RUN;
      tmo_cnt <= '0;
      err_tmo <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (dmem_req && !dmem_ready) begin
            state   <= MEM_WAIT;
            tmo_cnt <= TW'(1);
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state <= RUN;
          end else if (tmo_cnt == TMO_LAST) begin
            state   <= ERROR;
            err_tmo <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ERROR: begin
          if (err_clr) begin
            state   <= RUN;
            err_tmo <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stallF && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (flushE && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit against a behavioural model.
// Directed scenarios first, then randomized traffic with occasional resets.
module tb_hazard_ctrl_unit;

  localparam int TMO   = 4;
  localparam int CW    = 8;
  localparam int SATV  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          arst;
  logic [4:0]    rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic          regwriteE, resultsrcE, regwriteM, regwriteW;
  logic          pcsrcE, dmem_req, dmem_ready, err_clr, cnt_clr;
  logic [1:0]    forwardAE, forwardBE;
  logic          stallF, stallD, stallE, stallM, stallW;
  logic          flushD, flushE, err_tmo;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_chk = 0;
  int n_err = 0;

  // model: busy = waiting on memory, n = frozen cycles so far in this wait
  bit m_busy, m_err;
  int m_n, m_sc, m_fc;
  bit m_sF, m_fE;

  hazard_ctrl_unit #(.TMO_CYC(TMO), .CNT_W(CW)) dut (
    .clk(clk), .arst(arst),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .regwriteE(regwriteE), .resultsrcE(resultsrcE),
    .rdM(rdM), .rdW(rdW), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .pcsrcE(pcsrcE), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .err_clr(err_clr), .cnt_clr(cnt_clr),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .stallM(stallM), .stallW(stallW),
    .flushD(flushD), .flushE(flushE), .err_tmo(err_tmo),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(logic [4:0] rs);
    if (regwriteM && rdM != 0 && rdM == rs) return 2'd2;
    if (regwriteW && rdW != 0 && rdW == rs) return 2'd1;
    return 2'd0;
  endfunction

  task automatic idle();
    {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
    {regwriteE, resultsrcE, regwriteM, regwriteW} = '0;
    {pcsrcE, dmem_req, dmem_ready, err_clr, cnt_clr} = '0;
  endtask

  task automatic model_reset();
    m_busy = 0; m_err = 0; m_n = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic compare_all();
    logic [1:0] eA, eB;
    bit ld, fz, eS, eF, eFD, eFE;
    ld = resultsrcE && regwriteE && rdE != 0 &&
         (rdE == rs1D || rdE == rs2D);
    fz = m_err || (m_busy ? !dmem_ready : (dmem_req && !dmem_ready));
    if (arst) begin
      eA = 0; eB = 0; eS = 0; eF = 0; eFD = 1; eFE = 1;
    end else begin
      eA = ref_fwd(rs1E);
      eB = ref_fwd(rs2E);
      eF  = fz;
      eS  = fz || (!pcsrcE && ld);
      eFD = !fz && pcsrcE;
      eFE = !fz && (pcsrcE || ld);
    end
    m_sF = eS;
    m_fE = eFE;
    check("fwdA", 32'(forwardAE), 32'(eA));
    check("fwdB", 32'(forwardBE), 32'(eB));
    check("stallF", 32'(stallF), 32'(eS));
    check("stallD", 32'(stallD), 32'(eS));
    check("stallE", 32'(stallE), 32'(eF));
    check("stallM", 32'(stallM), 32'(eF));
    check("stallW", 32'(stallW), 32'(eF));
    check("flushD", 32'(flushD), 32'(eFD));
    check("flushE", 32'(flushE), 32'(eFE));
    check("err_tmo", 32'(err_tmo), 32'(m_err));
    check("stall_cnt", 32'(stall_cnt), 32'(m_sc));
    check("flush_cnt", 32'(flush_cnt), 32'(m_fc));
  endtask

  task automatic update_model();
    if (arst) begin
      model_reset();
      return;
    end
    if (cnt_clr) begin
      m_sc = 0; m_fc = 0;
    end else begin
      if (m_sF && m_sc < SATV) m_sc++;
      if (m_fE && m_fc < SATV) m_fc++;
    end
    if (m_err) begin
      if (err_clr) m_err = 0;
    end else if (m_busy) begin
      if (dmem_ready) m_busy = 0;
      else begin
        m_n++;
        if (m_n == TMO) begin
          m_err = 1; m_busy = 0;
        end
      end
    end else if (dmem_req && !dmem_ready) begin
      m_busy = 1; m_n = 1;
    end
  endtask

  // inputs are driven just after a posedge; checks at the negedge
  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    #1;
    model_reset();
    check("rst_err", 32'(err_tmo), 0);
    check("rst_scnt", 32'(stall_cnt), 0);
    check("rst_flushD", 32'(flushD), 1);
    step();
    arst = 1'b0;
  endtask

  task automatic rand_inputs();
    rs1D = 5'($urandom_range(0, 3));
    rs2D = 5'($urandom_range(0, 3));
    rs1E = 5'($urandom_range(0, 3));
    rs2E = 5'($urandom_range(0, 3));
    rdE  = 5'($urandom_range(0, 3));
    rdM  = 5'($urandom_range(0, 3));
    rdW  = 5'($urandom_range(0, 3));
    regwriteE  = 1'($urandom_range(0, 1));
    resultsrcE = 1'($urandom_range(0, 1));
    regwriteM  = 1'($urandom_range(0, 1));
    regwriteW  = 1'($urandom_range(0, 1));
    pcsrcE     = ($urandom_range(0, 4) == 0);
    dmem_req   = ($urandom_range(0, 2) == 0);
    dmem_ready = 1'($urandom_range(0, 1));
    err_clr    = ($urandom_range(0, 9) == 0);
    cnt_clr    = ($urandom_range(0, 29) == 0);
  endtask

  initial begin
    idle();
    arst = 1'b1;
    model_reset();
    #12;
    check("rst_fwdA", 32'(forwardAE), 0);
    check("rst_flushE", 32'(flushE), 1);
    check("rst_stallF", 32'(stallF), 0);
    @(posedge clk); #1;
    arst = 1'b0;
    step();

    // forwarding: M beats W, x0 never forwarded
    rdM = 5; regwriteM = 1; rdW = 5; regwriteW = 1; rs1E = 5;
    #1;
    check("fwd_m_wins", 32'(forwardAE), 2);
    step();
    rdM = 0; rdW = 0; rs1E = 0;
    #1;
    check("fwd_x0", 32'(forwardAE), 0);
    step();

    // load-use on rs2D
    idle();
    resultsrcE = 1; regwriteE = 1; rdE = 7; rs2D = 7;
    #1;
    check("ld_stallF", 32'(stallF), 1);
    check("ld_flushE", 32'(flushE), 1);
    check("ld_flushD", 32'(flushD), 0);
    step();
    check("ld_cnt", 32'(stall_cnt), 1);

    // redirect overrides load-use
    pcsrcE = 1;
    #1;
    check("rd_stallF", 32'(stallF), 0);
    check("rd_flushD", 32'(flushD), 1);
    step();
    idle();

    // three wait cycles then ready
    dmem_req = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mw_freeze", 32'(stallW), 1);
      step();
    end
    dmem_ready = 1;
    #1;
    check("mw_release", 32'(stallF), 0);
    step();
    idle();
    step();
    check("mw_noerr", 32'(err_tmo), 0);

    // timeout: 4 frozen cycles then error, ready ignored in error
    dmem_req = 1;
    for (int i = 0; i < TMO; i++) step();
    check("tmo_err", 32'(err_tmo), 1);
    dmem_req = 0; dmem_ready = 1;
    #1;
    check("err_frozen", 32'(stallE), 1);
    step();

    // saturate stall counter while frozen in error
    for (int i = 0; i < SATV + 5; i++) step();
    check("sat", 32'(stall_cnt), SATV);
    err_clr = 1;
    step();
    err_clr = 0;
    check("err_clr", 32'(err_tmo), 0);
    #1;
    check("clr_unfrz", 32'(stallF), 0);

    // reset in the middle of a memory wait
    dmem_req = 1; dmem_ready = 0;
    step();
    step();
    do_reset();
    idle();
    check("mid_rst_cnt", 32'(stall_cnt), 0);
    check("mid_rst_err", 32'(err_tmo), 0);
    step();
    #1;
    check("mid_rst_run", 32'(stallF), 0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rand_inputs();
      if ($urandom_range(0, 149) == 0) do_reset();
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
